// File: rtl/vram_fetch.sv
// Video bitplane fetcher sharing one byte-wide memory port with a CPU.
// Four plane bytes are fetched per video address and published as one 32-bit word.
module vram_fetch #(
    parameter logic PLANE_BASE = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_12mp,
    input  logic [12:0] vaddr,
    output logic [31:0] vdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VID  = 2'd1,
        S_CPU  = 2'd2
    } state_t;

    // Memory handshake: mem_req is held with stable address/data until the
    // one-cycle mem_ack; mem_ack is only honoured while mem_req is high, and
    // mem_req drops for one cycle after every ack.
    state_t      state_q, state_d;
    logic [1:0]  plane_q, plane_d;
    logic [12:0] last_q, last_d;
    logic        pend_q, pend_d;
    logic        force_q, force_d;
    logic [23:0] shadow_q, shadow_d;
    logic [31:0] vdata_q, vdata_d;
    logic [15:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]  cpu_data_q, cpu_data_d;
    logic        cpu_we_q, cpu_we_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        gap_q, gap_d;

    logic ack_ok;
    logic vid_new;
    logic pend_any;

    assign mem_req  = (state_q != S_IDLE) && !gap_q;
    assign ack_ok   = mem_ack && mem_req;
    assign vid_new  = ce_12mp && (vaddr != last_q);
    assign pend_any = pend_q || force_q || vid_new;

    always_comb begin
        state_d    = state_q;
        plane_d    = plane_q;
        last_d     = last_q;
        pend_d     = pend_q || vid_new;
        force_d    = force_q;
        shadow_d   = shadow_q;
        vdata_d    = vdata_q;
        cpu_addr_d = cpu_addr_q;
        cpu_data_d = cpu_data_q;
        cpu_we_d   = cpu_we_q;
        cpu_din_d  = cpu_din_q;
        cpu_ack_d  = 1'b0;
        gap_d      = ack_ok;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (pend_any) begin
                    state_d = S_VID;
                    last_d  = vaddr;
                    pend_d  = 1'b0;
                    force_d = 1'b0;
                    plane_d = 2'd0;
                end else if ((cpu_rd || cpu_wr) && !cpu_ack_q) begin
                    // cpu_ack_q blocks re-issuing the request still held in the ack cycle
                    state_d    = S_CPU;
                    cpu_addr_d = cpu_addr;
                    cpu_data_d = cpu_dout;
                    cpu_we_d   = cpu_wr;
                end
            end
            S_VID: begin
                mem_addr = {PLANE_BASE, plane_q, last_q};
                if (ack_ok) begin
                    case (plane_q)
                        2'd0:    shadow_d[23:16] = mem_rdata;
                        2'd1:    shadow_d[15:8]  = mem_rdata;
                        2'd2:    shadow_d[7:0]   = mem_rdata;
                        default: vdata_d         = {shadow_q, mem_rdata};
                    endcase
                    if (plane_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        plane_d = plane_q + 2'd1;
                    end
                end
            end
            S_CPU: begin
                mem_we    = cpu_we_q;
                mem_addr  = cpu_addr_q;
                mem_wdata = cpu_data_q;
                if (ack_ok) begin
                    cpu_ack_d = 1'b1;
                    if (!cpu_we_q) begin
                        cpu_din_d = mem_rdata;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            plane_q    <= 2'd0;
            last_q     <= 13'h0000;
            pend_q     <= 1'b0;
            force_q    <= 1'b1;
            shadow_q   <= 24'h000000;
            vdata_q    <= 32'h00000000;
            cpu_addr_q <= 16'h0000;
            cpu_data_q <= 8'h00;
            cpu_we_q   <= 1'b0;
            cpu_din_q  <= 8'h00;
            cpu_ack_q  <= 1'b0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            plane_q    <= plane_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            force_q    <= force_d;
            shadow_q   <= shadow_d;
            vdata_q    <= vdata_d;
            cpu_addr_q <= cpu_addr_d;
            cpu_data_q <= cpu_data_d;
            cpu_we_q   <= cpu_we_d;
            cpu_din_q  <= cpu_din_d;
            cpu_ack_q  <= cpu_ack_d;
            gap_q      <= gap_d;
        end
    end

    assign vdata       = vdata_q;
    assign cpu_din     = cpu_din_q;
    assign cpu_ack     = cpu_ack_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vram_fetch.sv
// Directed bench for vram_fetch: byte memory model with programmable latency,
// table of video fetch vectors, and hand sequences for CPU, preemption and reset cases.
module tb_vram_fetch;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    typedef struct {
        logic [12:0] va;
        int          lat;
        logic [31:0] pd;
        logic [15:0] addr0;
        logic [31:0] exp_vd;
    } vec_t;

    // clock / reset
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset = 1'b1;
    logic        ce_12mp = 1'b1;
    logic [12:0] vaddr = 13'h0;
    logic [31:0] vdata;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_dout = 8'h0;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h0;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_state;

    vram_fetch #(.PLANE_BASE(1'b1)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_12mp     (ce_12mp),
        .vaddr       (vaddr),
        .vdata       (vdata),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .cpu_ack     (cpu_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // memory model and monitors
    logic [7:0]  mem [0:65535];
    acc_t        log_q[$];
    logic [31:0] vd_hist[$];
    int          lat = 2;
    int          mem_cnt = 0;
    int          gap_viol = 0;
    int          ack_pulses = 0;
    int          cyc = 0;
    int          last_vd_cyc = 0;
    int          last_ack_cyc = 0;
    logic [31:0] vd_prev = 32'h0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (mem_ack) begin
            if (mem_req) gap_viol = gap_viol + 1;
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else if (mem_req) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt > lat) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        mem_rdata = mem[mem_addr];
                log_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem[mem_addr]});
                mem_ack = 1'b1;
            end
        end else begin
            mem_cnt = 0;
        end
        if (vdata !== vd_prev) begin
            vd_hist.push_back(vdata);
            vd_prev = vdata;
            last_vd_cyc = cyc;
        end
        if (cpu_ack) begin
            ack_pulses = ack_pulses + 1;
            last_ack_cyc = cyc;
        end
    end

    // scoreboard bookkeeping: bases mark the start of each scenario
    int log_base = 0;
    int vd_base = 0;
    int ack_base = 0;
    logic [31:0] exp_q[$];

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mark();
        log_base = log_q.size();
        vd_base  = vd_hist.size();
        ack_base = ack_pulses;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int i;
        i = 0;
        while ((log_q.size() - log_base) < n && i < budget) begin
            step();
            i++;
        end
        check({name, "_timeout"}, 32'(log_q.size() - log_base >= n), 32'd1);
    endtask

    function automatic acc_t acc(input int i);
        acc_t a;
        a = '0;
        if (log_base + i < log_q.size()) a = log_q[log_base + i];
        return a;
    endfunction

    // compare logged accesses against exp_q (each entry {we, addr, data} in low 25 bits)
    task automatic check_log(input string name);
        check({name, "_count"}, 32'(log_q.size() - log_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_acc%0d", name, i), 32'(acc(i)), exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic push_vid(input logic [15:0] addr0, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({7'd0, 1'b0, 16'(addr0 + 16'(i * 8192)), word[31 - 8*i -: 8]});
        end
    endtask

    task automatic preload(input logic [15:0] addr0, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            mem[16'(addr0 + 16'(i * 8192))] = word[31 - 8*i -: 8];
        end
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output logic ok);
        cpu_addr = a;
        cpu_dout = d;
        cpu_wr   = we;
        cpu_rd   = !we;
        ok = 1'b0;
        rd = 8'h00;
        for (int i = 0; i < 200; i++) begin
            step();
            if (cpu_ack) begin
                rd = cpu_din;
                ok = 1'b1;
                break;
            end
        end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        logic [7:0] rd;
        logic       ok;
        int         n42;

        vecs[0] = '{13'h1ABC, 3, 32'h01020304, 16'h9ABC, 32'h01020304};
        vecs[1] = '{13'h0010, 1, 32'hA55AFF00, 16'h8010, 32'hA55AFF00};
        vecs[2] = '{13'h1FFF, 4, 32'h80402010, 16'h9FFF, 32'h80402010};
        vecs[3] = '{13'h0100, 2, 32'hDEADBEEF, 16'h8100, 32'hDEADBEEF};

        preload(16'h8000, 32'h11223344);
        preload(16'h8011, 32'h31323334);
        preload(16'h8555, 32'h61626364);
        preload(16'h8123, 32'h71727374);

        // reset state
        repeat (3) step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_vdata", vdata, 32'h0);
        check("rst_cpu_din", 32'(cpu_din), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // forced fetch after reset with vaddr unchanged at 0
        mark();
        lat = 2;
        reset = 1'b0;
        wait_log(4, 100, "force");
        repeat (3) step();
        push_vid(16'h8000, 32'h11223344);
        check_log("force");
        check("force_vdata", vdata, 32'h11223344);
        check("force_vd_changes", 32'(vd_hist.size() - vd_base), 32'd1);

        // table of plain video fetches
        for (int k = 0; k < 4; k++) begin
            preload(vecs[k].addr0, vecs[k].pd);
            mark();
            lat = vecs[k].lat;
            vaddr = vecs[k].va;
            wait_log(4, 200, $sformatf("vec%0d", k));
            repeat (3) step();
            push_vid(vecs[k].addr0, vecs[k].exp_vd);
            check_log($sformatf("vec%0d", k));
            check($sformatf("vec%0d_vdata", k), vdata, vecs[k].exp_vd);
            check($sformatf("vec%0d_vd_changes", k), 32'(vd_hist.size() - vd_base), 32'd1);
        end

        // CPU write then read back
        lat = 2;
        mark();
        cpu_access(1'b1, 16'h1234, 8'h5A, rd, ok);
        repeat (3) step();
        check("cpuwr_ack", 32'(ok), 32'd1);
        check("cpuwr_pulses", 32'(ack_pulses - ack_base), 32'd1);
        exp_q.push_back({7'd0, 1'b1, 16'h1234, 8'h5A});
        check_log("cpuwr");
        mark();
        cpu_access(1'b0, 16'h1234, 8'h00, rd, ok);
        repeat (3) step();
        check("cpurd_ack", 32'(ok), 32'd1);
        check("cpurd_data", 32'(rd), 32'h5A);
        check("cpurd_din_held", 32'(cpu_din), 32'h5A);
        check("cpurd_pulses", 32'(ack_pulses - ack_base), 32'd1);
        exp_q.push_back({7'd0, 1'b0, 16'h1234, 8'h5A});
        check_log("cpurd");

        // CPU read and vaddr change together: video first
        mark();
        vaddr = 13'h0555;
        cpu_access(1'b0, 16'h1234, 8'h00, rd, ok);
        repeat (3) step();
        check("race_ack", 32'(ok), 32'd1);
        check("race_data", 32'(rd), 32'h5A);
        push_vid(16'h8555, 32'h61626364);
        exp_q.push_back({7'd0, 1'b0, 16'h1234, 8'h5A});
        check_log("race");
        check("race_vdata", vdata, 32'h61626364);
        check("race_vd_before_ack", 32'(last_vd_cyc < last_ack_cyc), 32'd1);

        // vaddr change after the plane-1 ack
        mark();
        lat = 3;
        vaddr = 13'h0010;
        wait_log(2, 100, "midchg_p1");
        step();
        vaddr = 13'h0011;
        wait_log(8, 300, "midchg");
        repeat (3) step();
        push_vid(16'h8010, 32'hA55AFF00);
        push_vid(16'h8011, 32'h31323334);
        check_log("midchg");
        check("midchg_vd_changes", 32'(vd_hist.size() - vd_base), 32'd2);
        check("midchg_first_word", (vd_hist.size() > vd_base) ? vd_hist[vd_base] : 32'hX, 32'hA55AFF00);
        check("midchg_vdata", vdata, 32'h31323334);

        // vaddr is ignored while ce_12mp is low
        mark();
        ce_12mp = 1'b0;
        vaddr = 13'h1ABC;
        repeat (20) step();
        check("ce_low_no_fetch", 32'(log_q.size() - log_base), 32'd0);
        ce_12mp = 1'b1;
        wait_log(4, 200, "ce_high");
        repeat (3) step();
        check("ce_high_vdata", vdata, 32'h01020304);

        // CPU write to a plane byte leaves vdata alone
        mark();
        cpu_access(1'b1, 16'h9ABC, 8'hEE, rd, ok);
        repeat (5) step();
        check("planewr_ack", 32'(ok), 32'd1);
        check("planewr_vdata", vdata, 32'h01020304);
        check("planewr_vd_changes", 32'(vd_hist.size() - vd_base), 32'd0);

        // reset while waiting on the plane-2 ack
        mark();
        lat = 4;
        vaddr = 13'h0123;
        wait_log(2, 100, "rstvid_p1");
        repeat (2) step();
        reset = 1'b1;
        step();
        check("rstvid_mem_req", 32'(mem_req), 32'd0);
        check("rstvid_vdata", vdata, 32'h0);
        check("rstvid_partial", 32'(log_q.size() - log_base), 32'd2);
        step();
        mark();
        reset = 1'b0;
        wait_log(4, 200, "rstvid_rerun");
        repeat (3) step();
        push_vid(16'h8123, 32'h71727374);
        check_log("rstvid_rerun");
        check("rstvid_vdata_after", vdata, 32'h71727374);

        // reset in the middle of a CPU read
        mark();
        cpu_addr = 16'h0042;
        cpu_rd = 1'b1;
        repeat (3) step();
        check("rstcpu_req_up", 32'(mem_req), 32'd1);
        reset = 1'b1;
        cpu_rd = 1'b0;
        step();
        check("rstcpu_mem_req", 32'(mem_req), 32'd0);
        step();
        reset = 1'b0;
        repeat (40) step();
        check("rstcpu_no_ack", 32'(ack_pulses - ack_base), 32'd0);
        n42 = 0;
        for (int i = log_base; i < log_q.size(); i++) begin
            if (log_q[i].addr == 16'h0042) n42++;
        end
        check("rstcpu_abandoned", 32'(n42), 32'd0);

        check("gap_between_accesses", 32'(gap_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
